// File: rtl/fifo_reader_pkg.sv
// Shared constants and helpers for the FIFO read-side adapter.
package fifo_reader_pkg;

  // Cycles between a sampled fifo_rd and valid fifo_q.
  localparam int FIFO_RD_LAT = 1;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Prefetch circular buffer: push/pop/clear with count and head word.
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 2,
  localparam int PW        = clog2_min1(DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CW-1:0]         count_o,
  output logic                  not_empty_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Clear wins over push/pop; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign count_o     = cnt_q;
  assign not_empty_o = (cnt_q != '0);
  assign head_o      = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_reader.sv
// Turns a fifo rd/q read port into a valid/ready stream via a prefetch buffer.
// Optional statistics counters are enabled with `define FIFO_READER_STATS_EN.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  flush,
  input  logic                  fifo_mty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [CNT_W-1:0]      word_cnt,
  output logic [CNT_W-1:0]      stall_cnt
`endif
);

  localparam int CW = clog2_min1(BUF_DEPTH) + 1;

  if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_reader: BUF_DEPTH must be a power of two and at least 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("fifo_reader: CNT_W must be at least 1");
  end
  if (FIFO_RD_LAT != 1) begin : g_bad_lat
    $error("fifo_reader: only a single-cycle fifo read latency is supported");
  end

  logic [CW-1:0]         buf_cnt;
  logic                  buf_ne;
  logic [DATA_WIDTH-1:0] buf_head;
  logic                  inflight_q, inflight_d;
  logic                  pop;
  logic                  capture;
  logic [CW:0]           demand;

  assign pop     = buf_ne & out_ready;
  assign capture = inflight_q & ~flush;

  // Slots already committed next cycle; a read is issued only if one stays free.
  assign demand  = {1'b0, buf_cnt} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign fifo_rd = arst & ~fifo_mty & ~flush & (demand < (CW+1)'(BUF_DEPTH));

  assign inflight_d = fifo_rd;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) inflight_q <= 1'b0;
    else       inflight_q <= inflight_d;
  end

  fifo_reader_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .arst        (arst),
    .clear_i     (flush),
    .push_i      (capture),
    .pop_i       (pop),
    .data_i      (fifo_q),
    .count_o     (buf_cnt),
    .not_empty_o (buf_ne),
    .head_o      (buf_head)
  );

  assign out_valid = buf_ne;
  assign out_data  = buf_head;
  assign busy      = buf_ne | inflight_q;

`ifdef FIFO_READER_STATS_EN
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall;

  assign stall = buf_ne & ~out_ready;

  // Saturating counters; flush deliberately leaves them alone.
  always_comb begin
    word_cnt_d  = word_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pop && word_cnt_q != '1)    word_cnt_d  = word_cnt_q + CNT_W'(1);
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign word_cnt  = word_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: queue-based FIFO and reference model plus directed scenarios.
module tb_fifo_reader;
  localparam int DW = 128;
  localparam int BD = 2;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          arst, flush, fifo_mty, fifo_rd, out_valid, out_ready, busy;
  logic [DW-1:0] fifo_q, out_data;
`ifdef FIFO_READER_STATS_EN
  logic [SW-1:0] word_cnt, stall_cnt;
`endif

  fifo_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(BD), .CNT_W(SW)) dut (
    .clk       (clk),
    .arst      (arst),
    .flush     (flush),
    .fifo_mty  (fifo_mty),
    .fifo_rd   (fifo_rd),
    .fifo_q    (fifo_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef FIFO_READER_STATS_EN
    ,
    .word_cnt  (word_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Upstream FIFO contents and the reference model's view of the prefetch buffer.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] mbuf[$];
  logic [DW-1:0] rx[$];
  bit            minfl = 1'b0;
  bit            m_valid, m_pop, m_rd, m_busy, rd_s;
  int            cyc_n = 0;
  int            rd_cnt = 0;
  int            first_valid_cyc = -1;
  int            first_pop_cyc = -1;
  int            last_pop_cyc = -1;

  always begin : model
    @(negedge clk);
    cyc_n++;
    m_valid = arst && (mbuf.size() != 0);
    m_pop   = m_valid && out_ready;
    m_rd    = arst && !fifo_mty && !flush &&
              ((int'(mbuf.size()) + int'(minfl) - int'(m_pop)) < BD);
    m_busy  = arst && ((mbuf.size() != 0) || minfl);
    check("out_valid", out_valid, m_valid);
    check("fifo_rd", fifo_rd, m_rd);
    check("busy", busy, m_busy);
    if (m_valid) check("out_data", out_data, mbuf[0]);
    else if (!arst) check("out_data_in_reset", out_data, '0);

    if (fifo_rd) rd_cnt++;
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc_n;
    if (out_valid && out_ready) begin
      rx.push_back(out_data);
      if (first_pop_cyc < 0) first_pop_cyc = cyc_n;
      last_pop_cyc = cyc_n;
    end
    rd_s = fifo_rd;

    if (!arst) begin
      mbuf.delete();
      minfl = 1'b0;
    end else begin
      if (flush) mbuf.delete();
      else begin
        if (m_pop) void'(mbuf.pop_front());
        if (minfl) mbuf.push_back(fifo_q);
      end
      minfl = m_rd;
    end

    @(posedge clk);
    #1;
    if (rd_s && fq.size() != 0) fifo_q = fq.pop_front();
    fifo_mty = (fq.size() == 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input int first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(DW'(first + i));
    fifo_mty = (fq.size() == 0);
  endtask

  task automatic clr();
    rx.delete();
    rd_cnt          = 0;
    first_valid_cyc = -1;
    first_pop_cyc   = -1;
    last_pop_cyc    = -1;
  endtask

  int mark;

  initial begin
    arst = 1'b1; flush = 1'b0; out_ready = 1'b0; fifo_mty = 1'b1; fifo_q = '0;
    #1 arst = 1'b0;
    #1;
    check("rst_fifo_rd", fifo_rd, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_busy", busy, 1'b0);
    cyc(2);
    arst = 1'b1;

    // Empty FIFO: never read.
    clr();
    cyc(20);
    check("no_rd_when_empty", rd_cnt, 0);

    // Streaming with out_ready held high.
    out_ready = 1'b1;
    clr();
    load(1, 16);
    mark = cyc_n;
    cyc(24);
    check("first_valid_latency", first_valid_cyc - (mark + 1), 2);
    check("stream_count", rx.size(), 16);
    check("stream_first", rx[0], 128'h01);
    check("stream_last", rx[15], 128'h10);
    check("stream_no_gaps", last_pop_cyc - first_pop_cyc, 15);

    // Backpressure: buffer fills to BD and reads stop.
    out_ready = 1'b0;
    clr();
    load(1, 16);
    cyc(10);
    check("bp_rd_pulses", rd_cnt, BD);
    check("bp_valid", out_valid, 1'b1);
    check("bp_data", out_data, 128'h01);
    cyc(5);
    check("bp_data_stable", out_data, 128'h01);
    check("bp_rd_still", rd_cnt, BD);
    out_ready = 1'b1;
    cyc(25);
    check("bp_drain_count", rx.size(), 16);
    check("bp_drain_first", rx[0], 128'h01);
    check("bp_drain_last", rx[15], 128'h10);

    // Flush in the cycle word 0x05 returns from the FIFO.
    clr();
    load(1, 16);
    cyc(5);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    check("flush_pops_before", rx.size(), 4);
    check("flush_valid_low", out_valid, 1'b0);
    clr();
    cyc(25);
    check("flush_after_count", rx.size(), 11);
    check("flush_after_first", rx[0], 128'h06);
    check("flush_after_last", rx[10], 128'h10);

    // Asynchronous reset mid-stream with a read in flight.
    clr();
    load(1, 16);
    cyc(4);
    arst = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, '0);
    check("mid_rst_rd", fifo_rd, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_pops_before", rx.size(), 2);
    cyc(2);
    arst = 1'b1;
    clr();
    cyc(25);
    check("post_rst_count", rx.size(), 12);
    check("post_rst_first", rx[0], 128'h05);
    check("post_rst_last", rx[11], 128'h10);

`ifdef FIFO_READER_STATS_EN
    arst = 1'b0;
    #1;
    check("stats_rst_word", word_cnt, 0);
    check("stats_rst_stall", stall_cnt, 0);
    cyc(1);
    arst = 1'b1;
    out_ready = 1'b0;
    load(1, 10);
    cyc(5);
    out_ready = 1'b1;
    cyc(20);
    check("stats_word", word_cnt, 10);
    check("stats_stall", stall_cnt, 3);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    cyc(2);
    check("stats_word_flush", word_cnt, 10);
    check("stats_stall_flush", stall_cnt, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
Read-side adapter for the synchronous `fifo` block. It converts the FIFO's `rd`/`q` read port into a valid/ready output stream using an internal prefetch buffer, and sustains one word per cycle when the consumer keeps `out_ready` high. It sits between a `fifo` instance and a downstream consumer, and never reads an empty FIFO.

Parameters:
- DATA_WIDTH, 128, width of FIFO `q` and of `out_data`.
- BUF_DEPTH, 2, prefetch buffer entries; minimum 2; power of two.
- CNT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- arst, input, 1, asynchronous active-low reset (assert low, async; release sync to clk externally).
- flush, input, 1, synchronous request to drop all buffered and in-flight words.
- fifo_mty, input, 1, FIFO empty flag.
- fifo_rd, output, 1, FIFO read strobe.
- fifo_q, input, DATA_WIDTH, FIFO read data; valid the cycle after `fifo_rd` is sampled high.
- out_valid, output, 1, output word valid.
- out_ready, input, 1, consumer accepts the word.
- out_data, output, DATA_WIDTH, output word (head of the buffer).
- busy, output, 1, high when `buf_cnt` or `inflight` is non-zero.

Behaviour:
- Reset (arst low), effective immediately:
  - fifo_rd=0, out_valid=0, out_data=0, busy=0.
  - Buffer pointers, `buf_cnt` and `inflight` cleared.
- State:
  - Circular buffer with wr_ptr and rd_ptr, each log2(BUF_DEPTH) bits, wrapping modulo BUF_DEPTH.
  - `buf_cnt`: 0..BUF_DEPTH.
  - `inflight`: 1 bit; set when `fifo_rd` issued, cleared next cycle.
- Pop and out_valid:
  - pop = out_valid & out_ready.
  - out_valid = (buf_cnt != 0); out_data = buf[rd_ptr].
  - No combinational path from fifo_q to the outputs.
- Read issue (combinational):
  - fifo_rd = !fifo_mty & !flush & (buf_cnt + inflight - pop < BUF_DEPTH).
  - Never asserted while fifo_mty=1, so no underflow.
- Capture: the cycle after fifo_rd=1, write fifo_q into buf[wr_ptr] and advance wr_ptr, unless flush is high in that cycle.
- Count update: buf_cnt_next = buf_cnt + capture - pop. Simultaneous capture and pop leaves the count unchanged.
- Throughput:
  - Steady state with out_ready=1 and a non-empty FIFO: one word per cycle.
  - First out_valid appears 2 cycles after fifo_mty falls: cycle N rd, cycle N+1 capture, cycle N+2 out_valid.
- Backpressure: with out_ready=0, at most BUF_DEPTH words are held and fifo_rd deasserts. out_data stays stable while out_valid=1 & !out_ready.
- Flush:
  - Clears buf_cnt, the pointers and inflight at the next edge.
  - A word returning from the FIFO in the flush cycle is discarded.
  - out_valid=0 from the next cycle; no fifo_rd in the flush cycle.
  - flush has priority over pop and capture.
- Reset mid-operation: all state is lost, and an in-flight FIFO word is not captured.
- Ordering: words leave in exactly FIFO order; no drops except on flush.

Optional Feature:
- Macro: FIFO_READER_STATS_EN.
- With the macro defined:
  - Extra outputs `word_cnt` [CNT_W] (count of pops) and `stall_cnt` [CNT_W] (cycles with out_valid & !out_ready).
  - Both counters saturate at all-ones, reset to 0 on arst, and are not cleared by flush.
- Without it: the ports and counters are absent, and the core behaviour is identical.

Decomposition:
- utils_pkg: add `FIFO_RD_LAT=1` and the function `clog2_min1(n)` used for pointer widths.
- Sub-module fifo_reader_buf: circular buffer plus pointers and count. Its interface is push/pop/clear, with data, count, not_empty, head. fifo_reader holds only the issue/inflight/flush logic and the stats.

Test Plan:
- Reset with fifo_mty=1 → fifo_rd, out_valid, out_data and busy all 0; no fifo_rd over 20 cycles.
- FIFO preloaded with 0x01..0x10, out_ready=1 → first out_valid 2 cycles after fifo_mty falls, then 16 consecutive words 0x01..0x10 with no gaps.
- out_ready=0 with 16 words in the FIFO → exactly BUF_DEPTH=2 fifo_rd pulses; out_data=0x01 holds stable. Raise out_ready → remaining words arrive in order.
- flush in the same cycle a read returns (word 0x05) → 0x05 and any buffered words are dropped, out_valid=0 next cycle, and the next output is 0x06 or later.
- arst pulsed low mid-stream with inflight=1 → outputs are 0 asynchronously; after release no stale word appears, and reads restart from the FIFO head.
- With FIFO_READER_STATS_EN, 10 pops and 3 stall cycles → word_cnt=10, stall_cnt=3; a flush leaves both unchanged.
